// File: rtl/dmp_rr_stream_merger_pkg.sv
// Shared types for the deterministic round-robin merge stage.
package dmp_pkg;

  localparam int unsigned DMP_DATA_W = 32;
  localparam int unsigned DMP_ID_W   = 32;

  // Contribution is unsigned Q16.16 fixed point.
  typedef logic [DMP_DATA_W-1:0] contrib_t;
  typedef logic [DMP_ID_W-1:0]   node_id_t;

  typedef struct packed {
    contrib_t contrib;
    node_id_t dest;
  } stream_beat_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MERGE = 2'd1,
    DONE  = 2'd2
  } merge_state_e;

  function automatic int unsigned ptr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dmp_rr_stream_merger_if.sv
// Per-thread scatter inputs and the merged serial output stream.
interface dmp_rr_stream_merger_if
  import dmp_pkg::*;
#(
  parameter int unsigned NUM_HW_THREADS = 8,
  parameter int unsigned DATA_W         = DMP_DATA_W,
  parameter int unsigned ID_W           = DMP_ID_W
);
  localparam int unsigned TW = ptr_w(NUM_HW_THREADS);

  logic [NUM_HW_THREADS-1:0]             in_valid;
  logic [NUM_HW_THREADS-1:0][DATA_W-1:0] in_contrib;
  logic [NUM_HW_THREADS-1:0][ID_W-1:0]   in_dest;
  logic [NUM_HW_THREADS-1:0]             in_done;
  logic [NUM_HW_THREADS-1:0]             stall_thread;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [DATA_W-1:0]                     out_contrib;
  logic [ID_W-1:0]                       out_dest;
  logic [TW-1:0]                         out_thread;

  modport slave (
    input  in_valid, in_contrib, in_dest, in_done, out_ready,
    output stall_thread, out_valid, out_contrib, out_dest, out_thread
  );

  modport master (
    output in_valid, in_contrib, in_dest, in_done, out_ready,
    input  stall_thread, out_valid, out_contrib, out_dest, out_thread
  );

endinterface

// File: rtl/dmp_rr_stream_merger_fifo.sv
// Single-clock per-thread FIFO; a push into a full FIFO is only taken
// when a pop happens in the same cycle.
module dmp_thread_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               wdata_i,
  output logic [W-1:0]               rdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/dmp_rr_stream_merger.sv
// Buffers per-thread scatter output and releases it as one stream in strict
// round-robin token order, so downstream accumulation order is timing-independent.
module dmp_rr_stream_merger
  import dmp_pkg::*;
#(
  parameter int unsigned NUM_HW_THREADS = 8,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned DATA_W         = DMP_DATA_W,
  parameter int unsigned ID_W           = DMP_ID_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   merge_start,
  dmp_rr_stream_merger_if.slave  strm,
  output logic                   merge_complete,
  output logic                   overflow_err
);
  localparam int unsigned TW = ptr_w(NUM_HW_THREADS);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BW = DATA_W + ID_W;
  localparam logic [TW-1:0] LAST = TW'(NUM_HW_THREADS - 1);

  merge_state_e state_q, state_d;
  logic [TW-1:0]             ptr_q, ptr_d, ptr_next;
  logic [NUM_HW_THREADS-1:0] done_q, done_d;
  logic [NUM_HW_THREADS-1:0] stall_q, stall_d;
  logic                      out_valid_q, out_valid_d;
  logic [DATA_W-1:0]         out_contrib_q, out_contrib_d;
  logic [ID_W-1:0]           out_dest_q, out_dest_d;
  logic [TW-1:0]             out_thread_q, out_thread_d;
  logic                      overflow_q, overflow_d;

  logic [NUM_HW_THREADS-1:0] pop, empty, full, drop;
  logic [BW-1:0]             rdata [NUM_HW_THREADS];
  logic [CW-1:0]             count [NUM_HW_THREADS];
  logic                      slot_free;

  for (genvar g = 0; g < NUM_HW_THREADS; g++) begin : g_fifo
    dmp_thread_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (BW)
    ) u_fifo (
      .clk     (clock),
      .rst     (reset),
      .push_i  (strm.in_valid[g]),
      .pop_i   (pop[g]),
      .wdata_i ({strm.in_contrib[g], strm.in_dest[g]}),
      .rdata_o (rdata[g]),
      .count_o (count[g]),
      .full_o  (full[g]),
      .empty_o (empty[g])
    );
    assign drop[g]    = strm.in_valid[g] & full[g] & ~pop[g];
    assign stall_d[g] = (count[g] >= CW'(FIFO_DEPTH - 1));
  end

  assign slot_free = ~out_valid_q | strm.out_ready;
  assign ptr_next  = (ptr_q == LAST) ? '0 : ptr_q + TW'(1);

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    done_d        = done_q | strm.in_done;
    out_valid_d   = out_valid_q;
    out_contrib_d = out_contrib_q;
    out_dest_d    = out_dest_q;
    out_thread_d  = out_thread_q;
    overflow_d    = overflow_q | (|drop);
    pop           = '0;

    if (out_valid_q && strm.out_ready) out_valid_d = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (merge_start) begin
          state_d = MERGE;
          ptr_d   = '0;
          done_d  = strm.in_done;
        end
      end
      MERGE: begin
        // An empty, not-yet-done thread holds the token: this wait is what
        // makes the output order independent of thread timing.
        if (slot_free) begin
          if ((&done_q) && (&empty)) begin
            state_d = DONE;
          end else if (!empty[ptr_q]) begin
            pop[ptr_q]                  = 1'b1;
            out_valid_d                 = 1'b1;
            {out_contrib_d, out_dest_d} = rdata[ptr_q];
            out_thread_d                = ptr_q;
            ptr_d                       = ptr_next;
          end else if (done_q[ptr_q]) begin
            ptr_d = ptr_next;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      done_q        <= '0;
      stall_q       <= '0;
      out_valid_q   <= 1'b0;
      out_contrib_q <= '0;
      out_dest_q    <= '0;
      out_thread_q  <= '0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      done_q        <= done_d;
      stall_q       <= stall_d;
      out_valid_q   <= out_valid_d;
      out_contrib_q <= out_contrib_d;
      out_dest_q    <= out_dest_d;
      out_thread_q  <= out_thread_d;
      overflow_q    <= overflow_d;
    end
  end

  assign strm.stall_thread = stall_q;
  assign strm.out_valid    = out_valid_q;
  assign strm.out_contrib  = out_contrib_q;
  assign strm.out_dest     = out_dest_q;
  assign strm.out_thread   = out_thread_q;
  assign merge_complete    = (state_q == DONE);
  assign overflow_err      = overflow_q;

endmodule

// File: tb/tb_dmp_rr_stream_merger.sv
// Self-checking bench for dmp_rr_stream_merger: randomized per-thread streams
// compared against a round-robin interleave model, plus directed corner cases.
module tb_dmp_rr_stream_merger;

  localparam int unsigned NT    = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned IW    = 32;
  localparam int unsigned MAXB  = 16;

  typedef struct packed {
    logic [1:0]    th;
    logic [DW-1:0] c;
    logic [IW-1:0] d;
  } beat_t;

  logic clock = 1'b0;
  logic reset;
  logic merge_start;
  logic merge_complete;
  logic overflow_err;

  dmp_rr_stream_merger_if #(.NUM_HW_THREADS(NT), .DATA_W(DW), .ID_W(IW)) bus ();

  dmp_rr_stream_merger #(
    .NUM_HW_THREADS (NT),
    .FIFO_DEPTH     (DEPTH),
    .DATA_W         (DW),
    .ID_W           (IW)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .merge_start    (merge_start),
    .strm           (bus),
    .merge_complete (merge_complete),
    .overflow_err   (overflow_err)
  );

  always #5 clock = ~clock;

  int unsigned checks = 0;
  int unsigned passes = 0;

  int unsigned   n_beats   [NT];
  logic [DW-1:0] p_c       [NT][MAXB];
  logic [IW-1:0] p_d       [NT][MAXB];
  int unsigned   start_dly [NT];
  int unsigned   pct_v;
  int unsigned   pct_r;
  int            hold_at;

  task automatic clear_inputs();
    bus.in_valid   = '0;
    bus.in_done    = '0;
    bus.in_contrib = '0;
    bus.in_dest    = '0;
  endtask

  task automatic pulse_start();
    @(negedge clock);
    merge_start = 1'b1;
    @(negedge clock);
    merge_start = 1'b0;
  endtask

  task automatic plan_random(input int unsigned maxn);
    for (int i = 0; i < NT; i++) begin
      n_beats[i]   = $urandom_range(maxn);
      start_dly[i] = $urandom_range(8);
      for (int k = 0; k < MAXB; k++) begin
        p_c[i][k] = $urandom;
        p_d[i][k] = $urandom;
      end
    end
  endtask

  // Runs one iteration from merge_start to merge_complete and compares the
  // stream with the round-robin interleave of the planned per-thread sequences.
  task automatic run_merge(input string name, input int unsigned budget);
    beat_t       exp_q[$];
    beat_t       got_q[$];
    beat_t       cur, held;
    int unsigned idx  [NT];
    int unsigned sent [NT];
    bit          any, finished, hold_pend;
    int unsigned cyc;

    for (int i = 0; i < NT; i++) idx[i] = 0;
    do begin
      any = 1'b0;
      for (int i = 0; i < NT; i++) begin
        if (idx[i] < n_beats[i]) begin
          cur.th = 2'(i);
          cur.c  = p_c[i][idx[i]];
          cur.d  = p_d[i][idx[i]];
          exp_q.push_back(cur);
          idx[i]++;
          any = 1'b1;
        end
      end
    end while (any);

    for (int i = 0; i < NT; i++) sent[i] = 0;
    finished  = 1'b0;
    hold_pend = 1'b0;
    held      = '0;
    cyc       = 0;
    clear_inputs();
    bus.out_ready = 1'b1;
    pulse_start();

    while (cyc < budget && !finished) begin
      cur.th = bus.out_thread;
      cur.c  = bus.out_contrib;
      cur.d  = bus.out_dest;
      if (hold_pend) begin
        checks++;
        if (bus.out_valid !== 1'b1 || cur !== held)
          $display("FAIL %s hold cyc=%0d: valid=%b beat=%h required valid=1 beat=%h",
                   name, cyc, bus.out_valid, cur, held);
        else passes++;
      end
      if (merge_complete === 1'b1) begin
        finished = 1'b1;
      end else begin
        if (hold_at >= 0 && cyc >= hold_at && cyc < hold_at + 3) bus.out_ready = 1'b0;
        else bus.out_ready = ($urandom_range(99) < pct_r);
        hold_pend = bus.out_valid && !bus.out_ready;
        held      = cur;
        if (bus.out_valid && bus.out_ready) got_q.push_back(cur);
        for (int i = 0; i < NT; i++) begin
          bus.in_valid[i] = 1'b0;
          if (cyc >= start_dly[i]) begin
            if (sent[i] < n_beats[i]) begin
              if (!bus.stall_thread[i] && $urandom_range(99) < pct_v) begin
                bus.in_valid[i]   = 1'b1;
                bus.in_contrib[i] = p_c[i][sent[i]];
                bus.in_dest[i]    = p_d[i][sent[i]];
                sent[i]++;
              end
            end else begin
              bus.in_done[i] = 1'b1;
            end
          end
        end
        @(negedge clock);
        cyc++;
      end
    end

    checks++;
    if (!finished) $display("FAIL %s timeout: merge_complete=%b after %0d cycles, required 1",
                            name, merge_complete, cyc);
    else passes++;

    checks++;
    if (got_q.size() != exp_q.size())
      $display("FAIL %s beat_count: got %0d required %0d", name, got_q.size(), exp_q.size());
    else passes++;

    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k])
        $display("FAIL %s beat[%0d]: got %h required %h", name, k, got_q[k], exp_q[k]);
      else passes++;
    end

    checks++;
    if (overflow_err !== 1'b0) $display("FAIL %s overflow: got %b required 0", name, overflow_err);
    else passes++;

    clear_inputs();
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    merge_start = 1'b0;
    clear_inputs();
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_contrib !== '0 || bus.out_dest !== '0 ||
        bus.out_thread !== '0)
      $display("FAIL reset_out: valid=%b contrib=%h dest=%h thread=%0d required all 0",
               bus.out_valid, bus.out_contrib, bus.out_dest, bus.out_thread);
    else passes++;
    checks++;
    if (bus.stall_thread !== '0 || merge_complete !== 1'b0 || overflow_err !== 1'b0)
      $display("FAIL reset_flags: stall=%b complete=%b overflow=%b required 0",
               bus.stall_thread, merge_complete, overflow_err);
    else passes++;
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_basic_rr();
    for (int i = 0; i < NT; i++) begin
      n_beats[i]   = 1;
      start_dly[i] = 0;
      p_c[i][0]    = 32'h0001_0000 * (i + 1);
      p_d[i][0]    = i;
    end
    pct_v   = 100;
    pct_r   = 100;
    hold_at = -1;
    run_merge("basic_rr", 200);
  endtask

  task automatic test_skew();
    bit bad = 1'b0;
    int unsigned w = 0;
    clear_inputs();
    bus.out_ready = 1'b1;
    pulse_start();
    bus.in_valid[1]   = 1'b1;
    bus.in_contrib[1] = 32'hAAAA_0001;
    bus.in_dest[1]    = 32'd11;
    bus.in_done[2]    = 1'b1;
    bus.in_done[3]    = 1'b1;
    repeat (5) begin
      @(negedge clock);
      bus.in_valid[1] = 1'b0;
      bus.in_done[1]  = 1'b1;
      if (bus.out_valid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) $display("FAIL skew_wait: out_valid=1 while thread 0 empty, required 0");
    else passes++;

    bus.in_valid[0]   = 1'b1;
    bus.in_contrib[0] = 32'h5555_0000;
    bus.in_dest[0]    = 32'd10;
    @(negedge clock);
    bus.in_valid[0] = 1'b0;
    bus.in_done[0]  = 1'b1;
    checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL skew_latency1: out_valid=%b required 0", bus.out_valid);
    else passes++;
    @(negedge clock);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_thread !== 2'd0 || bus.out_contrib !== 32'h5555_0000)
      $display("FAIL skew_first: valid=%b thread=%0d contrib=%h required 1/0/55550000",
               bus.out_valid, bus.out_thread, bus.out_contrib);
    else passes++;
    @(negedge clock);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_thread !== 2'd1 || bus.out_dest !== 32'd11)
      $display("FAIL skew_second: valid=%b thread=%0d dest=%0d required 1/1/11",
               bus.out_valid, bus.out_thread, bus.out_dest);
    else passes++;
    while (merge_complete !== 1'b1 && w < 20) begin
      @(negedge clock);
      w++;
    end
    checks++;
    if (merge_complete !== 1'b1) $display("FAIL skew_complete: merge_complete=%b required 1", merge_complete);
    else passes++;
    clear_inputs();
  endtask

  task automatic test_skip();
    for (int i = 0; i < NT; i++) begin
      n_beats[i]   = (i % 2 == 0) ? 2 : 0;
      start_dly[i] = 0;
      for (int k = 0; k < 2; k++) begin
        p_c[i][k] = $urandom;
        p_d[i][k] = $urandom;
      end
    end
    pct_v   = 100;
    pct_r   = 100;
    hold_at = -1;
    run_merge("skip", 200);
  endtask

  task automatic test_hold();
    plan_random(4);
    for (int i = 0; i < NT; i++) begin
      n_beats[i]   = 3;
      start_dly[i] = 0;
    end
    pct_v   = 100;
    pct_r   = 100;
    hold_at = 4;
    run_merge("hold", 400);
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      plan_random(10);
      pct_v   = $urandom_range(100, 30);
      pct_r   = $urandom_range(100, 20);
      hold_at = -1;
      run_merge("random", 3000);
    end
  endtask

  task automatic test_backpressure();
    clear_inputs();
    bus.out_ready = 1'b0;
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      bus.in_valid[2]   = 1'b1;
      bus.in_contrib[2] = 32'hB000_0000 + k;
      bus.in_dest[2]    = k;
      @(negedge clock);
      if (k == 1) begin
        checks++;
        if (bus.stall_thread[2] !== 1'b0)
          $display("FAIL bp_stall_early: stall=%b required 0 at count 2", bus.stall_thread[2]);
        else passes++;
      end
    end
    bus.in_valid[2] = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.stall_thread[2] !== 1'b1) $display("FAIL bp_stall: stall=%b required 1", bus.stall_thread[2]);
    else passes++;
    bus.in_valid[2] = 1'b1;
    @(negedge clock);
    checks++;
    if (overflow_err !== 1'b0) $display("FAIL bp_fill: overflow=%b required 0", overflow_err);
    else passes++;
    @(negedge clock);
    bus.in_valid[2] = 1'b0;
    checks++;
    if (overflow_err !== 1'b1 || bus.out_valid !== 1'b0)
      $display("FAIL bp_drop: overflow=%b valid=%b required 1/0", overflow_err, bus.out_valid);
    else passes++;
    repeat (2) @(negedge clock);
    checks++;
    if (overflow_err !== 1'b1) $display("FAIL bp_sticky: overflow=%b required 1", overflow_err);
    else passes++;
    reset = 1'b1;
    #1;
    checks++;
    if (overflow_err !== 1'b0 || bus.stall_thread !== '0)
      $display("FAIL bp_reset: overflow=%b stall=%b required 0", overflow_err, bus.stall_thread);
    else passes++;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    bus.out_ready = 1'b0;
    pulse_start();
    bus.in_valid[0]   = 1'b1;
    bus.in_contrib[0] = 32'hDEAD_0000;
    bus.in_valid[1]   = 1'b1;
    bus.in_contrib[1] = 32'hDEAD_0001;
    @(negedge clock);
    clear_inputs();
    @(negedge clock);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_contrib !== 32'hDEAD_0000)
      $display("FAIL rmid_pre: valid=%b contrib=%h required 1/dead0000",
               bus.out_valid, bus.out_contrib);
    else passes++;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_contrib !== '0 || bus.out_thread !== '0 ||
        merge_complete !== 1'b0 || bus.stall_thread !== '0)
      $display("FAIL rmid_async: valid=%b contrib=%h thread=%0d complete=%b stall=%b required 0",
               bus.out_valid, bus.out_contrib, bus.out_thread, merge_complete, bus.stall_thread);
    else passes++;
    @(negedge clock);
    reset = 1'b0;
    plan_random(3);
    pct_v   = 100;
    pct_r   = 100;
    hold_at = -1;
    run_merge("reset_mid_new", 400);
  endtask

  initial begin
    test_reset();
    test_basic_rr();
    test_skew();
    test_skip();
    test_hold();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
